pcie_flow_ctrl_rx: RTL and testbench
====================================

# pcie_flow_ctrl_rx

- Receive-side partner of the flow-control init transmitter.
- Consumes the received DLLP AXI-stream from the DLLP receive path and checks each DLLP's 16-bit CRC.
- Decodes InitFC1/InitFC2/UpdateFC DLLPs for the configured VC and latches the link partner's advertised P/NP/Cpl header and data credits.
- Drives `fc1_values_stored_o` / `fc2_values_stored_o`, which feed the transmitter's `fc1_values_stored_i` / `fc2_values_stored_i`.

## Interface

Parameters:
- `DATA_WIDTH`, 32, stream width. Only 32 is supported; any other value is an elaboration error.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, tkeep width.
- `USER_WIDTH`, 3, tuser width. tuser is ignored.
- `VC_ID`, 0, VC whose DLLPs are accepted. DLLPs for other VCs are CRC-checked, then discarded.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. Asynchronous and active-high (already decided).
- `clear_i`  in  1  synchronous restart (link down / DL_Inactive). Clears all state as reset does.
- `s_axis_tdata`  in  32  DLLP bytes. Byte0 is in `[7:0]`.
- `s_axis_tkeep`  in  4  byte enables.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tlast`  in  1  last beat of DLLP.
- `s_axis_tuser`  in  `USER_WIDTH`  unused.
- `s_axis_tready`  out  1  0 in reset, 1 otherwise. The block never back-pressures.
- `fc1_values_stored_o`  out  1  FI1 flag.
- `fc2_values_stored_o`  out  1  FI2 flag.
- `p_hdr_credits_o`, `np_hdr_credits_o`, `cpl_hdr_credits_o`  out  8 each  advertised header credits.
- `p_data_credits_o`, `np_data_credits_o`, `cpl_data_credits_o`  out  12 each  advertised data credits.
- `crc_err_count_o`  out  8  bad-CRC DLLPs. Saturates at 8'hFF.
- `malformed_count_o`  out  8  framing errors. Saturates at 8'hFF.

## Operation

DLLP framing is two beats:
- Beat A: tkeep=4'hF, tlast=0, carrying the 4 DLLP bytes.
- Beat B: tkeep=4'h3, tlast=1, carrying the CRC in `[15:0]`.

CRC check:
- Computed with a `pcie_datalink_crc` instance: `crcIn='1`, data = beat A tdata.
- The result is registered at beat A acceptance.
- Beat B is good when `tdata[15:0] == ~crc_r`, with the inversion applied per byte.

Decode, from byte0 of beat A:
- `[7:4]`: 4=InitFC1, C=InitFC2, 8=UpdateFC.
- `[5:4]` of the type nibble: 0=P, 1=NP, 2=Cpl.
- `[2:0]`: VC.
- Header credits = {byte1[5:0], byte2[7:6]}.
- Data credits = {byte2[3:0], byte3}.
- Any other type, including Ack/Nak, is discarded silently with no counter change.

Parser FSM:
- `ST_HDR`:
  - Valid beat with tlast=0 and tkeep=4'hF: register bytes and CRC, go to `ST_CRC`.
  - Valid beat with tlast=1: malformed_count++, stay in `ST_HDR`.
- `ST_CRC`:
  - Valid beat with tlast=1 and tkeep=4'h3: evaluate and commit, go to `ST_HDR`.
  - Valid beat with tlast=0: malformed_count++, go to `ST_DROP`.
  - Wrong tkeep with tlast=1: malformed_count++, go to `ST_HDR`.
- `ST_DROP`: discard beats until a beat with tlast=1, then go to `ST_HDR`.

Commit rules (good CRC and VC match):
- InitFC1 or InitFC2 of type T with `got_T`=0 and FI1=0: load T's hdr/data credits and set `got_T`.
- Later Init DLLPs of an already-captured type: ignored.
- Once FI1=1: Init values are never reloaded.
- FI1 sets when `got_P & got_NP & got_Cpl` holds after the commit.
- FI2 sets on a good InitFC2 or UpdateFC (any type, matching VC) received while FI1=1, or in the same commit that sets FI1. FI2 never sets without FI1.
- UpdateFC DLLPs do not modify the credit outputs.
- Bad CRC: crc_err_count++ and no other effect.

Clearing:
- `clear_i` clears the flags, the `got_*` bits, the credits, the counters and the FSM (to `ST_HDR`).
- `clear_i` has priority over a same-cycle commit or count.

## Timing

- Reset and clear values: all outputs 0 except `s_axis_tready`, which is 1 after reset deasserts and is 0 during reset.
- Credits and flags update on the clock edge that accepts beat B. They are visible the cycle after that handshake.
- Counters update on the edge that accepts the offending beat.
- Beats may have idle (tvalid=0) gaps anywhere. The FSM holds state across gaps.
- Reset mid-DLLP: FSM returns to `ST_HDR`. The partial DLLP is discarded with no count.
- Back-to-back DLLPs (beat B followed immediately by the next beat A) are accepted at full rate: one DLLP per 2 cycles.

## Test plan

1. **Good InitFC1 sequence.**
   - Stimulus: good InitFC1_P (hdr 8'h20, data 12'h010 → beat A 32'h1000_0840), then InitFC1_NP (hdr 8'h20, data 12'h020), then InitFC1_Cpl (hdr 8'h20, data 12'h010), all with correct CRC.
   - Response: `p_hdr_credits_o`=8'h20, `p_data_credits_o`=12'h010; FI1 rises exactly one cycle after the Cpl beat B handshake; FI2 stays 0.
2. **FI2 and no reload.**
   - Stimulus: after scenario 1, send InitFC2_P carrying hdr 8'h40.
   - Response: FI2=1 one cycle after its beat B; `p_hdr_credits_o` remains 8'h20.
3. **Bad CRC.**
   - Stimulus: InitFC1_P with its CRC bit 0 flipped.
   - Response: `crc_err_count_o`=1, credits unchanged, FI1=0; a following good copy of the same DLLP loads normally.
4. **Malformed framing.**
   - Stimulus: a beat A with tlast=1, then a beat A followed by a tlast=0 beat followed by a tlast=1 beat.
   - Response: `malformed_count_o`=2; the next good DLLP parses correctly.
5. **Wrong VC, then clear.**
   - Stimulus: InitFC1_P with VC=3.
   - Response: no credit or flag change.
   - Stimulus: `clear_i` asserted for 1 cycle in the same cycle as a good beat B.
   - Response: all outputs 0 the next cycle, with no commit.
6. **Async reset mid-DLLP.**
   - Stimulus: assert `rst_i` between beat A and beat B.
   - Response: outputs go to 0 immediately without waiting for a clock; after release, a stray beat B alone → `malformed_count_o`=1.

Source files
------------

// File: rtl/pcie_flow_ctrl_rx.sv
// Receive-side DLLP flow-control parser: CRC-checks two-beat DLLPs, latches the
// link partner's InitFC credits and raises the FI1/FI2 flags for the init transmitter.

module pcie_datalink_crc (
  input  logic [15:0] crcIn,
  input  logic [31:0] data,
  output logic [15:0] crcOut
);
  localparam logic [15:0] POLY = 16'h100B;

  logic [15:0] c;

  // Byte0 bit0 enters the register first.
  always_comb begin
    c = crcIn;
    for (int i = 0; i < 32; i++) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? POLY : 16'h0000);
    end
  end

  assign crcOut = c;
endmodule

module pcie_flow_ctrl_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3,
  parameter int VC_ID      = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic [7:0]            p_hdr_credits_o,
  output logic [7:0]            np_hdr_credits_o,
  output logic [7:0]            cpl_hdr_credits_o,
  output logic [11:0]           p_data_credits_o,
  output logic [11:0]           np_data_credits_o,
  output logic [11:0]           cpl_data_credits_o,
  output logic [7:0]            crc_err_count_o,
  output logic [7:0]            malformed_count_o
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("pcie_flow_ctrl_rx supports DATA_WIDTH=32 only");
  end

  typedef enum logic [1:0] {ST_HDR, ST_CRC, ST_DROP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       hdr_q, hdr_d;
  logic [15:0]       crc_q, crc_d;
  logic [2:0]        got_q, got_d;
  logic              fi1_q, fi1_d;
  logic              fi2_q, fi2_d;
  logic [2:0][7:0]   hcr_q, hcr_d;
  logic [2:0][11:0]  dcr_q, dcr_d;
  logic [7:0]        crc_err_q, crc_err_d;
  logic [7:0]        mal_q, mal_d;

  logic [15:0] crc_calc;
  logic        mal_inc, crc_inc, commit, crc_ok;
  logic [1:0]  typ, fc;
  logic        vc_ok, known;

  pcie_datalink_crc u_crc (
    .crcIn  (16'hFFFF),
    .data   (s_axis_tdata),
    .crcOut (crc_calc)
  );

  // Type nibble: [7:6] 01=InitFC1, 11=InitFC2, 10=UpdateFC; [5:4] selects P/NP/Cpl.
  assign typ    = hdr_q[7:6];
  assign fc     = hdr_q[5:4];
  assign vc_ok  = (hdr_q[2:0] == 3'(VC_ID));
  assign known  = (typ != 2'b00) && (fc != 2'b11);
  assign crc_ok = (s_axis_tdata[15:8] == ~crc_q[15:8]) && (s_axis_tdata[7:0] == ~crc_q[7:0]);

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    crc_d     = crc_q;
    got_d     = got_q;
    fi1_d     = fi1_q;
    fi2_d     = fi2_q;
    hcr_d     = hcr_q;
    dcr_d     = dcr_q;
    crc_err_d = crc_err_q;
    mal_d     = mal_q;
    mal_inc   = 1'b0;
    crc_inc   = 1'b0;
    commit    = 1'b0;

    case (state_q)
      ST_HDR: if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          mal_inc = 1'b1;
        end else if (s_axis_tkeep == 4'hF) begin
          hdr_d   = s_axis_tdata;
          crc_d   = crc_calc;
          state_d = ST_CRC;
        end else begin
          mal_inc = 1'b1;
          state_d = ST_DROP;
        end
      end
      ST_CRC: if (s_axis_tvalid) begin
        state_d = ST_HDR;
        if (!s_axis_tlast) begin
          mal_inc = 1'b1;
          state_d = ST_DROP;
        end else if (s_axis_tkeep != 4'h3) begin
          mal_inc = 1'b1;
        end else begin
          commit = 1'b1;
        end
      end
      ST_DROP: if (s_axis_tvalid && s_axis_tlast) state_d = ST_HDR;
      default: state_d = ST_HDR;
    endcase

    if (commit) begin
      if (!crc_ok) begin
        crc_inc = 1'b1;
      end else if (vc_ok && known) begin
        if (typ[0] && !fi1_q && !got_q[fc]) begin
          hcr_d[fc] = {hdr_q[13:8], hdr_q[23:22]};
          dcr_d[fc] = {hdr_q[19:16], hdr_q[31:24]};
          got_d[fc] = 1'b1;
        end
        if (&got_d) fi1_d = 1'b1;
        // FI2 follows an InitFC2/UpdateFC seen with FI1 already set or set by this commit.
        if (typ != 2'b01 && fi1_d) fi2_d = 1'b1;
      end
    end

    if (mal_inc && mal_q != 8'hFF)     mal_d     = mal_q + 8'd1;
    if (crc_inc && crc_err_q != 8'hFF) crc_err_d = crc_err_q + 8'd1;

    if (clear_i) begin
      state_d   = ST_HDR;
      hdr_d     = '0;
      crc_d     = '0;
      got_d     = '0;
      fi1_d     = 1'b0;
      fi2_d     = 1'b0;
      hcr_d     = '0;
      dcr_d     = '0;
      crc_err_d = '0;
      mal_d     = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_HDR;
      hdr_q     <= '0;
      crc_q     <= '0;
      got_q     <= '0;
      fi1_q     <= 1'b0;
      fi2_q     <= 1'b0;
      hcr_q     <= '0;
      dcr_q     <= '0;
      crc_err_q <= '0;
      mal_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      crc_q     <= crc_d;
      got_q     <= got_d;
      fi1_q     <= fi1_d;
      fi2_q     <= fi2_d;
      hcr_q     <= hcr_d;
      dcr_q     <= dcr_d;
      crc_err_q <= crc_err_d;
      mal_q     <= mal_d;
    end
  end

  assign s_axis_tready       = ~rst_i;
  assign fc1_values_stored_o = fi1_q;
  assign fc2_values_stored_o = fi2_q;
  assign p_hdr_credits_o     = hcr_q[0];
  assign np_hdr_credits_o    = hcr_q[1];
  assign cpl_hdr_credits_o   = hcr_q[2];
  assign p_data_credits_o    = dcr_q[0];
  assign np_data_credits_o   = dcr_q[1];
  assign cpl_data_credits_o  = dcr_q[2];
  assign crc_err_count_o     = crc_err_q;
  assign malformed_count_o   = mal_q;

  logic unused_ok;
  assign unused_ok = ^{s_axis_tuser, hdr_q[3], hdr_q[15:14], hdr_q[21:20]};

endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// Directed bench for pcie_flow_ctrl_rx with a DLLP-level reference model checked every cycle.

module tb_pcie_flow_ctrl_rx;
  localparam int VC = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [2:0]  tuser = '0;
  logic        tready, fi1, fi2;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr, crc_err, mal;
  logic [11:0] p_dat, np_dat, cpl_dat;

  int checks = 0;
  int failures = 0;

  // Reference model state, indexed 0=P 1=NP 2=Cpl
  logic [7:0]  m_hdr [3];
  logic [11:0] m_dat [3];
  bit          m_got [3];
  bit          m_fi1, m_fi2;
  int          m_crc_err, m_mal;

  always #5 clk = ~clk;

  pcie_flow_ctrl_rx #(.VC_ID(VC)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready),
    .fc1_values_stored_o(fi1), .fc2_values_stored_o(fi2),
    .p_hdr_credits_o(p_hdr), .np_hdr_credits_o(np_hdr), .cpl_hdr_credits_o(cpl_hdr),
    .p_data_credits_o(p_dat), .np_data_credits_o(np_dat), .cpl_data_credits_o(cpl_dat),
    .crc_err_count_o(crc_err), .malformed_count_o(mal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [31:0] d);
    logic [15:0] r;
    logic [7:0]  byt;
    logic        msb;
    r = 16'hFFFF;
    for (int n = 0; n < 4; n++) begin
      byt = d[8*n +: 8];
      for (int k = 0; k < 8; k++) begin
        msb = r[15];
        r = r << 1;
        if (msb ^ byt[k]) r = r ^ 16'h100B;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] nib, input logic [2:0] vc,
                                     input logic [7:0] h, input logic [11:0] d);
    logic [7:0] b0, b1, b2, b3;
    b0 = {nib, 1'b0, vc};
    b1 = {2'b00, h[7:2]};
    b2 = {h[1:0], 2'b00, d[11:8]};
    b3 = d[7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hdr[i] = '0; m_dat[i] = '0; m_got[i] = 1'b0;
    end
    m_fi1 = 1'b0; m_fi2 = 1'b0; m_crc_err = 0; m_mal = 0;
  endtask

  task automatic model_mal();
    if (m_mal < 255) m_mal++;
  endtask

  task automatic model_dllp(input logic [3:0] nib, input logic [2:0] vc,
                            input logic [7:0] h, input logic [11:0] d, input bit good);
    int kind, t;
    if (!good) begin
      if (m_crc_err < 255) m_crc_err++;
      return;
    end
    case (nib)
      4'h4, 4'h5, 4'h6: begin kind = 1; t = int'(nib) - 4;  end
      4'hC, 4'hD, 4'hE: begin kind = 2; t = int'(nib) - 12; end
      4'h8, 4'h9, 4'hA: begin kind = 3; t = int'(nib) - 8;  end
      default: return;
    endcase
    if (int'(vc) != VC) return;
    if (kind != 3 && !m_fi1 && !m_got[t]) begin
      m_hdr[t] = h; m_dat[t] = d; m_got[t] = 1'b1;
    end
    if (!m_fi1 && m_got[0] && m_got[1] && m_got[2]) m_fi1 = 1'b1;
    if (kind != 1 && m_fi1) m_fi2 = 1'b1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_dllp(input logic [3:0] nib, input logic [2:0] vc, input logic [7:0] h,
                           input logic [11:0] d, input bit bad, input int gap);
    logic [31:0] a;
    logic [15:0] c;
    a = mk(nib, vc, h, d);
    c = ~ref_crc(a);
    if (bad) c[0] = ~c[0];
    beat(a, 4'hF, 1'b0);
    idle(gap);
    beat({16'h0, c}, 4'h3, 1'b1);
    model_dllp(nib, vc, h, d, !bad);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
  endtask

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    chk("tready",   {31'b0, tready}, {31'b0, ~rst});
    chk("fi1",      {31'b0, fi1}, {31'b0, m_fi1});
    chk("fi2",      {31'b0, fi2}, {31'b0, m_fi2});
    chk("p_hdr",    32'(p_hdr),   32'(m_hdr[0]));
    chk("np_hdr",   32'(np_hdr),  32'(m_hdr[1]));
    chk("cpl_hdr",  32'(cpl_hdr), 32'(m_hdr[2]));
    chk("p_dat",    32'(p_dat),   32'(m_dat[0]));
    chk("np_dat",   32'(np_dat),  32'(m_dat[1]));
    chk("cpl_dat",  32'(cpl_dat), 32'(m_dat[2]));
    chk("crc_err",  32'(crc_err), 32'(m_crc_err));
    chk("mal",      32'(mal),     32'(m_mal));
  end

  initial begin
    logic [31:0] a;
    logic [15:0] c;
    model_reset();
    #1;
    chk("rst_tready", {31'b0, tready}, 32'd0);
    chk("rst_fi1",    {31'b0, fi1},    32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_tready", {31'b0, tready}, 32'd1);
    @(posedge clk); #1;

    // 1: InitFC1 P/NP/Cpl
    send_dllp(4'h4, 3'(VC), 8'h20, 12'h010, 1'b0, 0);
    chk("s1_p_hdr", 32'(p_hdr), 32'h20);
    chk("s1_p_dat", 32'(p_dat), 32'h010);
    send_dllp(4'h5, 3'(VC), 8'h20, 12'h020, 1'b0, 2);
    chk("s1_fi1_early", {31'b0, fi1}, 32'd0);
    send_dllp(4'h6, 3'(VC), 8'h20, 12'h010, 1'b0, 0);
    chk("s1_fi1",    {31'b0, fi1}, 32'd1);
    chk("s1_fi2",    {31'b0, fi2}, 32'd0);
    chk("s1_np_dat", 32'(np_dat), 32'h020);

    // 2: InitFC2 sets FI2 without reload; UpdateFC leaves credits alone
    send_dllp(4'hC, 3'(VC), 8'h40, 12'h080, 1'b0, 0);
    chk("s2_fi2",   {31'b0, fi2}, 32'd1);
    chk("s2_p_hdr", 32'(p_hdr), 32'h20);
    send_dllp(4'h8, 3'(VC), 8'h7F, 12'hFFF, 1'b0, 1);
    chk("s2_upd_p_hdr", 32'(p_hdr), 32'h20);
    idle(1);
    do_clear();

    // 3: bad CRC, then a good copy
    send_dllp(4'h4, 3'(VC), 8'h20, 12'h010, 1'b1, 0);
    chk("s3_crc_err", 32'(crc_err), 32'd1);
    chk("s3_p_hdr",   32'(p_hdr), 32'h0);
    chk("s3_fi1",     {31'b0, fi1}, 32'd0);
    send_dllp(4'h4, 3'(VC), 8'h20, 12'h010, 1'b0, 0);
    chk("s3_good_p_hdr", 32'(p_hdr), 32'h20);
    do_clear();

    // 4: malformed framing
    beat(mk(4'h4, 3'(VC), 8'h20, 12'h010), 4'hF, 1'b1);
    model_mal();
    beat(mk(4'h5, 3'(VC), 8'h20, 12'h010), 4'hF, 1'b0);
    beat(32'hDEAD_BEEF, 4'hF, 1'b0);
    model_mal();
    beat(32'h0000_1234, 4'h3, 1'b1);
    chk("s4_mal", 32'(mal), 32'd2);
    send_dllp(4'h5, 3'(VC), 8'h33, 12'h123, 1'b0, 0);
    chk("s4_np_hdr", 32'(np_hdr), 32'h33);
    chk("s4_np_dat", 32'(np_dat), 32'h123);

    // 5: wrong VC ignored, then clear beats a same-cycle commit
    send_dllp(4'h4, 3'd3, 8'h55, 12'h555, 1'b0, 0);
    chk("s5_vc_p_hdr", 32'(p_hdr), 32'h0);
    a = mk(4'h4, 3'(VC), 8'h20, 12'h010);
    c = ~ref_crc(a);
    beat(a, 4'hF, 1'b0);
    tdata = {16'h0, c}; tkeep = 4'h3; tlast = 1'b1; tvalid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; clear = 1'b0;
    model_reset();
    chk("s5_clr_p_hdr",  32'(p_hdr), 32'h0);
    chk("s5_clr_np_hdr", 32'(np_hdr), 32'h0);
    chk("s5_clr_mal",    32'(mal), 32'h0);

    // 6: async reset between beat A and beat B
    send_dllp(4'h6, 3'(VC), 8'h11, 12'hABC, 1'b0, 0);
    chk("s6_cpl_dat", 32'(cpl_dat), 32'hABC);
    beat(mk(4'h4, 3'(VC), 8'h20, 12'h010), 4'hF, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("s6_async_cpl_dat", 32'(cpl_dat), 32'h0);
    chk("s6_async_tready",  {31'b0, tready}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    beat(32'h0000_5A5A, 4'h3, 1'b1);
    model_mal();
    chk("s6_mal", 32'(mal), 32'd1);
    send_dllp(4'h4, 3'(VC), 8'h2A, 12'h3C5, 1'b0, 0);
    chk("s6_p_hdr", 32'(p_hdr), 32'h2A);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
